fifo_wr_arbiter: RTL

- Round-robin arbiter that shares the single write port of the FIFO memory among NUM_REQ producers, all in the write-clock domain.
- Grants one producer at a time and holds the grant for a burst of up to MAX_BURST beats.
- Applies FIFO `full` backpressure to the granted producer and drives the memory's `w_en` / `data_in`.
- Sits directly in front of the FIFO write port; write-pointer and full-flag logic stay outside this block.

---
 rtl/fifo_wr_arbiter_if.sv | 30 +++
 rtl/fifo_wr_arbiter.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter_if.sv
// Bundle between NUM_REQ producers, the round-robin write arbiter and the FIFO write port.
// Latency: none, this is wiring only.
// Backpressure: the FIFO full flag reaches producers only through req_ready, which the arbiter drives.
interface fifo_wr_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 20,
    parameter int ID_W       = 2
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_last;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          full;
    logic                          w_en;
    logic [DATA_WIDTH-1:0]         data_in;
    logic [ID_W-1:0]               src_id;
    logic                          busy;

    // Producer/FIFO side: drives requests and full, observes grant and write strobes.
    modport master (
        output req_valid, req_last, req_data, full,
        input  req_ready, w_en, data_in, src_id, busy
    );

    // Arbiter side.
    modport slave (
        input  req_valid, req_last, req_data, full,
        output req_ready, w_en, data_in, src_id, busy
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers; grant held for bursts of up to MAX_BURST beats.
// Latency: first beat is written one cycle after valid is seen in IDLE; one IDLE bubble between consecutive grants.
// Backpressure: FIFO full gates req_ready/w_en of the granted producer and freezes grant, beat count and state.
// Optional per-producer beat statistics are compiled in with ARB_STATS_EN.
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 20,
    parameter int MAX_BURST  = 4,
    parameter int ID_W       = 2,
    parameter int CNT_W      = 4
) (
    input  logic                wclk,
    input  logic                wrst_n,
    fifo_wr_arbiter_if.slave    bus
`ifdef ARB_STATS_EN
    ,
    input  logic [ID_W-1:0]     stat_sel,
    output logic [15:0]         stat_cnt,
    output logic                stat_ovf
`endif
);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_BURST = 1'b1;

    logic [0:0]            state_q, state_d;
    logic [ID_W-1:0]       grant_q, grant_d;
    logic [ID_W-1:0]       last_grant_q, last_grant_d;
    logic [CNT_W-1:0]      beat_cnt_q, beat_cnt_d;
    logic [DATA_WIDTH-1:0] data_hold_q;

    logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];
    logic [NUM_REQ-1:0]    ready_w;
    logic                  in_burst;
    logic                  cur_vld;
    logic                  cur_last;
    logic                  xfer;
    logic                  found;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign data_arr[gi] = bus.req_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end

    assign in_burst = (state_q == S_BURST);
    assign cur_vld  = bus.req_valid[grant_q];
    assign cur_last = bus.req_last[grant_q];
    assign xfer     = in_burst & cur_vld & ~bus.full;

    // Only the granted producer sees ready, and only while the FIFO has room.
    always_comb begin
        ready_w = '0;
        if (in_burst) begin
            ready_w[grant_q] = ~bus.full;
        end
    end

    assign bus.req_ready = ready_w;
    assign bus.w_en      = xfer;
    // Outside a burst the last written word is presented; it is meaningless while w_en is low.
    assign bus.data_in   = in_burst ? data_arr[grant_q] : data_hold_q;
    assign bus.src_id    = grant_q;
    assign bus.busy      = in_burst;

    // Arbitration in IDLE, burst accounting and release conditions in BURST.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        beat_cnt_d   = beat_cnt_q;
        found        = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Search starts just after the last served producer, so it ends up lowest priority.
                for (int k = 1; k <= NUM_REQ; k++) begin
                    if (!found && bus.req_valid[ID_W'((int'(last_grant_q) + k) % NUM_REQ)]) begin
                        found   = 1'b1;
                        grant_d = ID_W'((int'(last_grant_q) + k) % NUM_REQ);
                    end
                end
                if (found) begin
                    state_d    = S_BURST;
                    beat_cnt_d = '0;
                end
            end
            S_BURST: begin
                if (xfer) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (cur_last || (beat_cnt_q == CNT_W'(MAX_BURST - 1))) begin
                        state_d      = S_IDLE;
                        last_grant_d = grant_q;
                    end
                end else if (!cur_vld && !bus.full) begin
                    // Idle producer gives the port back so others are not locked out.
                    state_d      = S_IDLE;
                    last_grant_d = grant_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers; the written word is kept for display outside bursts.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state_q      <= S_IDLE;
            grant_q      <= '0;
            last_grant_q <= ID_W'(NUM_REQ - 1);
            beat_cnt_q   <= '0;
            data_hold_q  <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            beat_cnt_q   <= beat_cnt_d;
            if (xfer) begin
                data_hold_q <= data_arr[grant_q];
            end
        end
    end

`ifdef ARB_STATS_EN
    logic [15:0] stat_q [NUM_REQ];
    logic        ovf_q;

    // Saturating per-producer beat counters with a sticky saturation flag.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                stat_q[i] <= '0;
            end
            ovf_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (xfer && (grant_q == ID_W'(i)) && (stat_q[i] != 16'hFFFF)) begin
                    stat_q[i] <= stat_q[i] + 16'd1;
                    if (stat_q[i] == 16'hFFFE) begin
                        ovf_q <= 1'b1;
                    end
                end
            end
        end
    end

    assign stat_cnt = (int'(stat_sel) < NUM_REQ) ? stat_q[stat_sel] : 16'h0000;
    assign stat_ovf = ovf_q;
`endif

endmodule
